mem_size_responder: RTL and testbench

//  Memory-side responder for CPU load/store requests of word, halfword or byte size.
//  - Sits between the CPU datapath and the word-wide synchronous Memoria.
//  - Aligns addresses and performs read-modify-write for sub-word stores.
//  - Zero-extends sub-word loads and flags misaligned or illegal requests.
//  - One request in flight; single-cycle response pulse.

---
 rtl/mem_size_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_size_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_size_responder.sv
// Word/halfword/byte load-store responder in front of a word-wide synchronous memory.
// Sub-word stores are read-modify-write; sub-word loads return the zero-extended lane.
module mem_size_responder #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam logic [2:0] READ_LAST = 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic [2:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_req_err;
  logic        w_word_store;
  logic        w_read_done;
  logic [3:0]  w_lane_sel;
  logic [31:0] w_lane_mask;
  logic [31:0] w_wsrc;
  logic [31:0] w_merged;
  logic [31:0] w_load;

  assign w_accept     = i_req_valid & r_req_ready;
  assign w_req_err    = (i_req_size == SZ_ILL)
                      | ((i_req_size == SZ_HALF) & i_req_addr[0])
                      | ((i_req_size == SZ_WORD) & (i_req_addr[1:0] != 2'b00));
  assign w_word_store = i_req_write & (i_req_size == SZ_WORD);
  assign w_read_done  = (r_cnt == READ_LAST);

  // Store data replicated across lanes so each lane mux only picks memory vs. new data.
  assign w_wsrc = (r_size == SZ_BYTE) ? {4{r_wdata[7:0]}} : {2{r_wdata}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign w_lane_sel[gi] = (r_size == SZ_WORD)
                          | ((r_size == SZ_HALF) & (r_off[1] == LANE[1]))
                          | ((r_size == SZ_BYTE) & (r_off == LANE));
    assign w_lane_mask[8*gi +: 8] = {8{w_lane_sel[gi]}};
    assign w_merged[8*gi +: 8]    = w_lane_sel[gi] ? w_wsrc[8*gi +: 8] : i_mem_rdata[8*gi +: 8];
  end

  assign w_load = (i_mem_rdata & w_lane_mask) >> {r_off, 3'b000};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= SZ_WORD;
      r_off        <= 2'b00;
      r_wdata      <= 16'h0000;
      r_cnt        <= 3'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write     <= i_req_write;
            r_size      <= i_req_size;
            r_off       <= i_req_addr[1:0];
            r_wdata     <= i_req_wdata[15:0];
            r_cnt       <= 3'd0;
            r_req_ready <= 1'b0;
            if (w_req_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (w_word_store) begin
              r_state     <= S_WRITE;
              r_mem_addr  <= {i_req_addr[31:2], 2'b00};
              r_mem_wdata <= i_req_wdata;
            end else begin
              r_state    <= S_READ;
              r_mem_addr <= {i_req_addr[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          if (w_read_done) begin
            if (r_write) begin
              r_state     <= S_WRITE;
              r_mem_wdata <= w_merged;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_load;
              r_mem_addr   <= 32'h0;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_mem_addr   <= 32'h0;
          r_mem_wdata  <= 32'h0;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_addr   = r_mem_addr;
  // Decoded from the state register so an asynchronous reset drops the write strobe at once.
  assign o_mem_wr     = (r_state == S_WRITE);
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_size_responder.sv
// Randomized scoreboard bench for mem_size_responder at MEM_LATENCY 1 and 3,
// each instance with its own memory model and reference model.
module tb_mem_size_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL L%0d %s: got %h expected %h (cycle %0d)", lat, name, act, req, cyc);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 1 : 3;

    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, mem_wr;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    resp_t       rq[$];
    wr_t         wq[$];
    resp_t       e_r;
    wr_t         e_w;
    int          acc_c = 1, due_c = 0, ra_lo = 1, ra_hi = 0;
    logic [31:0] ra_val = 32'h0;
    logic        mon_en = 1'b0;
    logic        done = 1'b0;
    logic [31:0] last_a = 32'h0;
    int          stable = 0;

    mem_size_responder #(.MEM_LATENCY(L)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .i_req_write(req_write), .i_req_size(req_size),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
      .o_resp_err(resp_err), .o_mem_addr(mem_addr), .o_mem_wr(mem_wr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Memory: data becomes valid only after the address has been held for L cycles.
    always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    always @(negedge clk) begin
      if (mem_addr == last_a && !mem_wr) stable++;
      else stable = 0;
      last_a = mem_addr;
      mem_rdata = (stable >= L - 1) ? mem[mem_addr[9:2]] : ~mem[mem_addr[9:2]];
    end

    // Reference model: expected response and memory write for one accepted request.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int          e0, lat, sh, idx;
      logic        err;
      logic [31:0] word, aa, mask, rd, nw;
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = d;
      for (int k = 0; k < 40 && !req_ready; k++) @(negedge clk);
      if (!req_ready) begin
        chk("accept_timeout", L, req_ready, 1'b1);
        req_valid = 1'b0;
        return;
      end
      e0   = cyc;
      aa   = {a[31:2], 2'b00};
      idx  = int'(a[9:2]);
      sh   = int'(a[1:0]) * 8;
      err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd0 && a[1:0] != 2'd0);
      word = ref_mem[idx];
      mask = (sz == 2'd0) ? 32'hFFFF_FFFF : (sz == 2'd1) ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
      rd   = 32'h0;
      if (err) begin
        lat = 1; ra_lo = e0 + 1; ra_hi = e0 + 1; ra_val = 32'h0;
      end else if (!w) begin
        lat = L + 1; rd = (word & mask) >> sh;
        ra_lo = e0 + 1; ra_hi = e0 + L; ra_val = aa;
      end else if (sz == 2'd0) begin
        lat = 2; wq.push_back('{aa, d, e0 + 1}); ref_mem[idx] = d;
        ra_lo = e0 + 1; ra_hi = e0 + 1; ra_val = aa;
      end else begin
        lat = L + 2; nw = (word & ~mask) | ((d << sh) & mask);
        wq.push_back('{aa, nw, e0 + L + 1}); ref_mem[idx] = nw;
        ra_lo = e0 + 1; ra_hi = e0 + L + 1; ra_val = aa;
      end
      rq.push_back('{rd, err, e0 + lat});
      acc_c = e0 + 1;
      due_c = e0 + lat;
      @(negedge clk);
    endtask

    task automatic idle(input int n);
      req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3)); req_addr = $urandom; req_wdata = $urandom;
      repeat (n) @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a response.
    always @(negedge clk) begin
      if (mon_en) begin
        logic idle_exp;
        idle_exp = !(cyc >= acc_c && cyc <= due_c);
        chk("req_ready", L, req_ready, idle_exp);
        if (idle_exp) chk("idle_mem_addr", L, mem_addr, 32'h0);
        if (cyc >= ra_lo && cyc <= ra_hi) chk("mem_addr", L, mem_addr, ra_val);
        if (!mem_wr) chk("mem_wdata_idle", L, mem_wdata, 32'h0);
        if (mem_wr) begin
          if (wq.size() == 0) chk("unexpected_write", L, mem_wr, 1'b0);
          else begin
            e_w = wq.pop_front();
            chk("wr_addr", L, mem_addr, e_w.addr);
            chk("wr_data", L, mem_wdata, e_w.data);
            chk("wr_cycle", L, cyc, e_w.due);
          end
        end else if (wq.size() != 0 && wq[0].due < cyc) begin
          chk("missing_write", L, mem_wr, 1'b1);
          void'(wq.pop_front());
        end
        if (resp_valid) begin
          if (rq.size() == 0) chk("unexpected_resp", L, resp_valid, 1'b0);
          else begin
            e_r = rq.pop_front();
            $display("L%0d resp cycle %0d rdata %h err %0d", L, cyc, resp_rdata, resp_err);
            chk("resp_cycle", L, cyc, e_r.due);
            chk("resp_rdata", L, resp_rdata, e_r.rdata);
            chk("resp_err", L, resp_err, e_r.err);
          end
        end else begin
          chk("rdata_idle", L, resp_rdata, 32'h0);
          if (rq.size() != 0 && rq[0].due < cyc) begin
            chk("missing_resp", L, resp_valid, 1'b1);
            void'(rq.pop_front());
          end
        end
      end
    end

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[8'h40] = 32'h1122_3344;
      mem[8'h80] = 32'hAABB_CCDD;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

      @(negedge clk);
      chk("rst_ready", L, req_ready, 1'b1);
      chk("rst_resp_valid", L, resp_valid, 1'b0);
      chk("rst_resp_rdata", L, resp_rdata, 32'h0);
      chk("rst_resp_err", L, resp_err, 1'b0);
      chk("rst_mem_addr", L, mem_addr, 32'h0);
      chk("rst_mem_wr", L, mem_wr, 1'b0);
      chk("rst_mem_wdata", L, mem_wdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Word store, then reset asserted in the middle of its WRITE cycle.
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
      req_addr = 32'h0000_0300; req_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_write_wr", L, mem_wr, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("async_wr_drop", L, mem_wr, 1'b0);
      chk("async_resp_valid", L, resp_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_rst_ready", L, req_ready, 1'b1);
      chk("post_rst_resp_valid", L, resp_valid, 1'b0);
      chk("post_rst_mem_addr", L, mem_addr, 32'h0);
      @(negedge clk);
      mon_en = 1'b1;

      issue(1'b0, 2'b10, 32'h0000_0102, 32'h0);
      idle(2);
      issue(1'b1, 2'b01, 32'h0000_0202, 32'hFFFF_1234);
      idle(2);
      issue(1'b1, 2'b00, 32'h0000_0300, 32'hDEAD_BEEF);
      idle(1);
      issue(1'b0, 2'b00, 32'h0000_0101, 32'h0);
      idle(1);
      issue(1'b0, 2'b11, 32'h0000_0100, 32'h0);
      idle(1);
      issue(1'b0, 2'b01, 32'h0000_0103, 32'h0);
      idle(1);
      issue(1'b0, 2'b01, 32'h0000_0100, 32'h0);
      issue(1'b0, 2'b01, 32'h0000_0100, 32'h0);
      idle(2);

      for (int n = 0; n < 150; n++) begin
        logic [1:0]  sz;
        logic [31:0] a;
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a  = $urandom & 32'h0000_FFFF;
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'b00) a[1:0] = 2'b00;
          if (sz == 2'b01) a[0] = 1'b0;
        end
        if (a[31:2] == 30'd0) a[2] = 1'b1;
        issue(1'($urandom_range(0, 1)), sz, a, $urandom);
        if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
      end
      idle(L + 6);
      chk("resp_queue_drained", L, rq.size(), 32'h0);
      chk("write_queue_drained", L, wq.size(), 32'h0);
      done = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && !(g_inst[0].done && g_inst[1].done); t++) @(negedge clk);
    chk("bench_timeout", 0, {31'b0, g_inst[0].done & g_inst[1].done}, 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
